// File: rtl/stage4_lsu_multi_pkg.sv
`default_nettype none
// ==================================================================
// tcore_param -- shared LSU types, access encodings and cause codes
// Rev 1.0
// ==================================================================
package tcore_param;

    localparam int XLEN = 32;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_BYTE = 2'b01;
    localparam logic [1:0] RW_HALF = 2'b10;
    localparam logic [1:0] RW_WORD = 2'b11;

    localparam logic [4:0] LD_LB  = 5'b00001;
    localparam logic [4:0] LD_LH  = 5'b00010;
    localparam logic [4:0] LD_LW  = 5'b00100;
    localparam logic [4:0] LD_LBU = 5'b01000;
    localparam logic [4:0] LD_LHU = 5'b10000;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CACHE  = 2'd1,
        PERIPH = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic            ready;
        logic            rw;
        logic [1:0]      rw_type;
        logic [XLEN-1:0] data;
        logic            uncached;
    } dcache_req_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] data;
    } dcache_res_t;

endpackage
`default_nettype wire

// File: rtl/stage4_lsu_multi_if.sv
`default_nettype none
// ==================================================================
// stage4_lsu_multi_if -- data-cache and peripheral bus bundle
// Rev 1.0
// ==================================================================
interface stage4_lsu_multi_if #(
    parameter int NUM_PERIPH = 2
);
    import tcore_param::*;

    dcache_req_t                  dcache_req;
    dcache_res_t                  dcache_res;
    logic [NUM_PERIPH-1:0]        p_stb;
    logic                         p_we;
    logic [3:0]                   p_adr;
    logic [3:0]                   p_sel;
    logic [XLEN-1:0]              p_wdat;
    logic [NUM_PERIPH*XLEN-1:0]   p_rdat;
    logic [NUM_PERIPH-1:0]        p_ack;

    modport master (
        output dcache_req, p_stb, p_we, p_adr, p_sel, p_wdat,
        input  dcache_res, p_rdat, p_ack
    );

    modport slave (
        input  dcache_req, p_stb, p_we, p_adr, p_sel, p_wdat,
        output dcache_res, p_rdat, p_ack
    );

endinterface
`default_nettype wire

// File: rtl/stage4_lsu_multi_align.sv
`default_nettype none
// ==================================================================
// lsu_align -- store lane placement, byte enables and load extension
// Rev 1.0
// ==================================================================
module lsu_align
    import tcore_param::*;
(
    input  wire logic [1:0]      rw_type_i,
    input  wire logic [1:0]      addr_lo_i,
    input  wire logic            wr_i,
    input  wire logic [4:0]      ld_op_i,
    input  wire logic [XLEN-1:0] wdata_i,
    input  wire logic [XLEN-1:0] rdata_i,
    output logic      [XLEN-1:0] wdata_o,
    output logic      [3:0]      sel_o,
    output logic      [XLEN-1:0] ldata_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        wdata_o = '0;
        sel_o   = '0;
        case (rw_type_i)
            RW_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                sel_o   = 4'b0001 << addr_lo_i;
            end
            RW_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                sel_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            RW_WORD: begin
                wdata_o = wdata_i;
                sel_o   = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Anything other than exactly one extension bit yields zero.
    always_comb begin
        ldata_o = '0;
        if (!wr_i) begin
            case (ld_op_i)
                LD_LB:   ldata_o = {{24{w_byte[7]}}, w_byte};
                LD_LH:   ldata_o = {{16{w_half[15]}}, w_half};
                LD_LW:   ldata_o = rdata_i;
                LD_LBU:  ldata_o = {24'd0, w_byte};
                LD_LHU:  ldata_o = {16'd0, w_half};
                default: ldata_o = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage4_lsu_multi.sv
`default_nettype none
// ==================================================================
// stage4_lsu_multi -- memory-stage LSU: data cache + peripheral channels
// Rev 1.0
// ==================================================================
module stage4_lsu_multi
    import tcore_param::*;
#(
    parameter int          NUM_PERIPH  = 2,
    parameter logic [31:0] PERIPH_BASE = 32'h2000_0000,
    parameter logic [31:0] PERIPH_MASK = 32'hF000_0000,
    parameter int          TIMEOUT     = 255
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            req_valid_i,
    input  wire logic            wr_en_i,
    input  wire logic [1:0]      rw_type_i,
    input  wire logic [4:0]      ld_op_size_i,
    input  wire logic [XLEN-1:0] addr_i,
    input  wire logic [XLEN-1:0] wdata_i,
    stage4_lsu_multi_if.master   bus,
    output logic                 stall_o,
    output logic      [XLEN-1:0] me_data_o,
    output logic                 excp_valid_o,
    output logic      [3:0]      excp_cause_o,
    output logic      [XLEN-1:0] excp_tval_o
);

    localparam int                CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);

    lsu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    me_data_q, me_data_d;
    logic [XLEN-1:0]    addr_q, wdata_q;
    logic [1:0]         size_q;
    logic               wr_q;
    logic [4:0]         ldop_q;
    logic [2:0]         ch_q;

    logic               w_accept, w_misalign, w_is_periph, w_badch, w_reject, w_capture;
    logic               w_sel_ack;
    logic [XLEN-1:0]    w_prdata, w_rdata_src, w_lane_wdata, w_ld_data;
    logic [3:0]         w_lane_sel;

    // Reset gates acceptance so no combinational pulse escapes while rst_i is high.
    assign w_accept    = !rst_i && (state_q == IDLE) && req_valid_i && (rw_type_i != RW_NONE);
    assign w_misalign  = ((rw_type_i == RW_HALF) && addr_i[0]) ||
                         ((rw_type_i == RW_WORD) && (addr_i[1:0] != 2'b00));
    assign w_is_periph = ((addr_i & PERIPH_MASK) == PERIPH_BASE);
    assign w_badch     = w_is_periph && ({29'd0, addr_i[18:16]} >= 32'(NUM_PERIPH));
    assign w_reject    = w_accept && (w_misalign || w_badch);
    assign w_capture   = w_accept && !w_reject;

    always_comb begin
        w_sel_ack = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (ch_q == 3'(i)) begin
                w_sel_ack = bus.p_ack[i];
                w_prdata  = bus.p_rdat[i*XLEN +: XLEN];
            end
        end
    end

    assign w_rdata_src = (state_q == CACHE) ? bus.dcache_res.data : w_prdata;

    lsu_align u_align (
        .rw_type_i (size_q),
        .addr_lo_i (addr_q[1:0]),
        .wr_i      (wr_q),
        .ld_op_i   (ldop_q),
        .wdata_i   (wdata_q),
        .rdata_i   (w_rdata_src),
        .wdata_o   (w_lane_wdata),
        .sel_o     (w_lane_sel),
        .ldata_o   (w_ld_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            me_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            me_data_q <= me_data_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= RW_NONE;
            wr_q    <= 1'b0;
            ldop_q  <= '0;
            ch_q    <= '0;
        end else if (w_capture) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            size_q  <= rw_type_i;
            wr_q    <= wr_en_i;
            ldop_q  <= ld_op_size_i;
            ch_q    <= addr_i[18:16];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        me_data_d      = me_data_q;
        stall_o        = 1'b0;
        excp_valid_o   = 1'b0;
        excp_cause_o   = '0;
        excp_tval_o    = '0;
        bus.dcache_req = '0;
        bus.p_stb      = '0;
        bus.p_we       = 1'b0;
        bus.p_adr      = '0;
        bus.p_sel      = '0;
        bus.p_wdat     = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (w_reject) begin
                    excp_valid_o = 1'b1;
                    excp_tval_o  = addr_i;
                    if (w_misalign)
                        excp_cause_o = wr_en_i ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                    else
                        excp_cause_o = wr_en_i ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                end else if (w_accept) begin
                    stall_o = 1'b1;
                    state_d = w_is_periph ? PERIPH : CACHE;
                end
            end

            CACHE: begin
                stall_o                 = 1'b1;
                bus.dcache_req.valid    = 1'b1;
                bus.dcache_req.addr     = addr_q;
                bus.dcache_req.ready    = 1'b1;
                bus.dcache_req.rw       = wr_q;
                bus.dcache_req.rw_type  = size_q;
                bus.dcache_req.data     = w_lane_wdata;
                bus.dcache_req.uncached = 1'b0;
                if (bus.dcache_res.valid) begin
                    state_d = RESP;
                    if (!wr_q)
                        me_data_d = w_ld_data;
                end
            end

            PERIPH: begin
                stall_o    = 1'b1;
                bus.p_we   = wr_q;
                bus.p_adr  = addr_q[5:2];
                bus.p_sel  = w_lane_sel;
                bus.p_wdat = w_lane_wdata;
                for (int i = 0; i < NUM_PERIPH; i++)
                    bus.p_stb[i] = (ch_q == 3'(i));
                if (w_sel_ack) begin
                    state_d = RESP;
                    if (!wr_q)
                        me_data_d = w_ld_data;
                end else if (cnt_q == TO_VAL) begin
                    // Strobe stays up through the final wait cycle, then the fault fires.
                    excp_valid_o = 1'b1;
                    excp_cause_o = wr_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                    excp_tval_o  = addr_q;
                    state_d      = RESP;
                    if (!wr_q)
                        me_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign me_data_o = me_data_q;

endmodule
`default_nettype wire

// File: doc/stage4_lsu_multi.md
STAGE4_LSU_MULTI -- requirements
Module: stage4_lsu_multi

Interface
REQ-001 Parameter NUM_PERIPH, default 2: peripheral channel count, 1..8.
REQ-002 Parameter PERIPH_BASE, default 32'h2000_0000, and PERIPH_MASK, default 32'hF000_0000: the peripheral region is (addr & PERIPH_MASK) == PERIPH_BASE.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for a peripheral acknowledge.
REQ-004 clk_i  in  1  clock; one clock domain.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i  in  1  a memory operation is present in the memory stage.
REQ-007 wr_en_i  in  1  1 = store, 0 = load.
REQ-008 rw_type_i  in  2  access size: 01 byte, 10 half, 11 word, 00 none.
REQ-009 ld_op_size_i  in  5  one-hot load extension: [0] LB, [1] LH, [2] LW, [3] LBU, [4] LHU.
REQ-010 addr_i / wdata_i  in  XLEN  effective address / store data.
REQ-011 dcache_req_o  out  dcache_req_t  fields valid, addr, ready, rw, rw_type, data, uncached.
REQ-012 dcache_res_i  in  dcache_res_t  fields valid, data.
REQ-013 p_stb_o / p_we_o  out  NUM_PERIPH / 1  per-channel strobe / write enable.
REQ-014 p_adr_o  out  4  word offset, addr[5:2].
REQ-015 p_sel_o  out  4  byte enables.
REQ-016 p_wdat_o  out  XLEN  store data.
REQ-017 p_rdat_i  in  NUM_PERIPH*XLEN  per-channel read data.
REQ-018 p_ack_i  in  NUM_PERIPH  per-channel acknowledge.
REQ-019 stall_o  out  1  hold the pipeline.
REQ-020 me_data_o  out  XLEN  extended load result.
REQ-021 excp_valid_o  out  1  one-cycle exception pulse.
REQ-022 excp_cause_o  out  4  exception cause code.
REQ-023 excp_tval_o  out  XLEN  faulting address.

Function
REQ-024 States SHALL be IDLE, CACHE, PERIPH, RESP. An operation is accepted in IDLE when req_valid_i & |rw_type_i.
REQ-025 Misalignment (half with addr[0]=1; word with addr[1:0]!=0) SHALL issue no bus access. It pulses excp_valid_o in the acceptance cycle, cause 4 for load and 6 for store, tval = addr_i, and stall_o = 0.
REQ-026 A peripheral address with channel addr[18:16] >= NUM_PERIPH SHALL raise an access fault the same way, cause 5 for load and 7 for store.
REQ-027 Store lane placement: byte -> wdata replicated x4, sel = 1<<addr[1:0]; half -> replicated x2, sel = 3<<(2*addr[1]); word -> sel = 4'hF.
REQ-028 Cacheable path: IDLE->CACHE. dcache_req_o.valid is held with constant fields until dcache_res_i.valid, then the state moves to RESP. uncached = 0.
REQ-029 Peripheral path: IDLE->PERIPH. p_stb_o[ch], p_we_o, p_sel_o and p_adr_o are held until p_ack_i[ch], then rdata is captured and the state moves to RESP. Ack on a non-selected channel SHALL be ignored.
REQ-030 The timeout counter starts at 0 in PERIPH. If it reaches TIMEOUT without ack: strobe drops, cause 5/7 is pulsed with tval, and the state moves to RESP with data 0.
REQ-031 stall_o SHALL be 1 in the acceptance cycle of a valid access and throughout CACHE/PERIPH. It is 0 in RESP, the single cycle in which me_data_o is valid.
REQ-032 Load extension per ld_op_size_i SHALL use the captured byte addr[1:0] or half addr[1]. Non-one-hot input gives 0. Stores return 0.
REQ-033 me_data_o SHALL hold its value until the next load completes.
REQ-034 RESP->IDLE unconditionally; back-to-back accesses therefore have at least 1 idle gap.
REQ-035 Address, size, rw and store data SHALL be registered at acceptance; changes on the inputs mid-operation are ignored.

Reset
REQ-036 Asynchronous reset SHALL force state IDLE, counter 0, and all outputs 0, including me_data_o, stall_o, p_stb_o and dcache_req_o.valid.
REQ-037 Reset mid-operation SHALL abandon the transaction immediately with no exception pulse.

Structure
REQ-038 The cause codes and the lsu_state_e enum SHALL live in tcore_param. PERIPH_BASE, PERIPH_MASK and TIMEOUT are module parameters.
REQ-039 Sub-module lsu_align (lane placement, byte enables, load extension) SHALL be purely combinational and instantiated once.

Verification
REQ-040 LW to 0x0000_1004, cache res.valid after 3 cycles with 0xDEADBEEF -> stall_o high for 4 cycles, then me_data_o = 0xDEADBEEF.
REQ-041 LB to 0x0000_1003 with word 0x80FF_FFFF -> me_data_o = 0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-042 SH 0x1234 to 0x2001_0002 -> p_stb_o = 2'b10, p_sel_o = 4'b1100, p_wdat_o = 0x1234_1234, p_adr_o = 0.
REQ-043 LW to 0x0000_1002 -> excp_valid_o pulse, cause 4, tval 0x0000_1002, no dcache valid, stall_o = 0.
REQ-044 Peripheral load with ack never asserted, TIMEOUT = 4 -> strobe for 5 cycles, cause 5, me_data_o = 0.
REQ-045 rst_i asserted while in PERIPH -> p_stb_o = 0 and state IDLE in the same cycle; no exception pulse.
